// File: rtl/multi_player_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : multi_player_game_controller
// Brief    : Turn-based pinball sequencer owning per-player lives/scores,
//            turn rotation, launch/ball-lost pacing and game-over/winner.
//            Optional macro HIGH_SCORE_EN adds a persistent high-score register.
// Revision : 1.0 - initial release
// ============================================================================
module multi_player_game_controller #(
    parameter int NUM_PLAYERS  = 2,
    parameter int LIVES_INIT   = 3,
    parameter int LIVES_MAX    = 9,
    parameter int SCORE_W      = 8,
    parameter int RESET_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               start,
    input  logic               key5IsPressed,
    input  logic               collisionBallObstacleGood,
    input  logic               collisionBallObstacleBad,
    input  logic               collisionBallBottom,
    input  logic               collisionBallCredit,
    input  logic [3:0]         scoreNumber,
    output logic               pause,
    output logic               reset_level,
    output logic               reset_level_pulse,
    output logic [3:0]         life,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         currentPlayer,
    output logic               gameOver,
    output logic [1:0]         winner,
    output logic [SCORE_W-1:0] highScore
);
    localparam int                 SLOTS      = 4;
    localparam int                 CNT_W      = $clog2(RESET_FRAMES + 1);
    localparam logic [CNT_W-1:0]   FRAME_LAST = CNT_W'(RESET_FRAMES - 1);
    localparam logic [3:0]         LIFE_INIT  = 4'(LIVES_INIT);
    localparam logic [3:0]         LIFE_MAX   = 4'(LIVES_MAX);
    localparam logic [2:0]         PLAYERS    = 3'(NUM_PLAYERS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_PLAY      = 3'd2,
        S_BALL_LOST = 3'd3,
        S_NEXT      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [3:0]         lives  [SLOTS];
    logic [SCORE_W-1:0] scores [SLOTS];
    logic [1:0]         cur, next_player;
    logic               good_q, bad_q, bottom_q, credit_q;
    logic               good_e, bad_e, bottom_e, credit_e;
    logic [CNT_W-1:0]   frame_cnt;
    logic               launch_pulse;
    logic               any_alive;
    logic [2:0]         cand;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] number, score_add, score_sub, best;

    assign good_e   = collisionBallObstacleGood & ~good_q;
    assign bad_e    = collisionBallObstacleBad  & ~bad_q;
    assign bottom_e = collisionBallBottom       & ~bottom_q;
    assign credit_e = collisionBallCredit       & ~credit_q;

    assign number    = SCORE_W'(scoreNumber);
    assign sum       = {1'b0, score} + {1'b0, number};
    assign score_add = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    assign score_sub = (score < number) ? '0 : score - number;

    assign life              = lives[cur];
    assign score             = scores[cur];
    assign currentPlayer     = cur;
    assign pause             = (state != S_PLAY);
    assign reset_level       = (state != S_PLAY);
    assign reset_level_pulse = launch_pulse;
    assign gameOver          = (state == S_GAME_OVER);

    // Walk candidates from farthest to nearest so the nearest living player wins.
    always_comb begin
        next_player = cur;
        any_alive   = 1'b0;
        cand        = 3'd0;
        for (int k = NUM_PLAYERS; k >= 1; k--) begin
            cand = {1'b0, cur} + 3'(k);
            if (cand >= PLAYERS) begin
                cand = cand - PLAYERS;
            end
            if (lives[cand[1:0]] != 4'd0) begin
                any_alive   = 1'b1;
                next_player = cand[1:0];
            end
        end
    end

    always_comb begin
        winner = 2'd0;
        best   = scores[0];
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (scores[2'(i)] > best) begin
                best   = scores[2'(i)];
                winner = 2'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_GAME_OVER: if (start)         state_next = S_LAUNCH;
            S_LAUNCH:            if (key5IsPressed) state_next = S_PLAY;
            S_PLAY:              if (bottom_e)      state_next = S_BALL_LOST;
            S_BALL_LOST: begin
                if (startOfFrame && frame_cnt == FRAME_LAST) state_next = S_NEXT;
            end
            S_NEXT:  state_next = any_alive ? S_LAUNCH : S_GAME_OVER;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cur          <= 2'd0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            bottom_q     <= 1'b0;
            credit_q     <= 1'b0;
            frame_cnt    <= '0;
            launch_pulse <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                lives[2'(i)]  <= 4'd0;
                scores[2'(i)] <= '0;
            end
        end else begin
            state        <= state_next;
            good_q       <= collisionBallObstacleGood;
            bad_q        <= collisionBallObstacleBad;
            bottom_q     <= collisionBallBottom;
            credit_q     <= collisionBallCredit;
            launch_pulse <= (state_next == S_LAUNCH) && (state != S_LAUNCH);
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (start) begin
                        cur <= 2'd0;
                        for (int i = 0; i < SLOTS; i++) begin
                            lives[2'(i)]  <= (i < NUM_PLAYERS) ? LIFE_INIT : 4'd0;
                            scores[2'(i)] <= '0;
                        end
                    end
                end
                S_PLAY: begin
                    // Only the highest-priority edge of the cycle takes effect.
                    if (bottom_e) begin
                        frame_cnt <= '0;
                        if (lives[cur] != 4'd0) lives[cur] <= lives[cur] - 4'd1;
                    end else if (bad_e) begin
                        scores[cur] <= score_sub;
                    end else if (good_e) begin
                        scores[cur] <= score_add;
                    end else if (credit_e && lives[cur] < LIFE_MAX) begin
                        lives[cur] <= lives[cur] + 4'd1;
                    end
                end
                S_BALL_LOST: if (startOfFrame) frame_cnt <= frame_cnt + 1'b1;
                S_NEXT:      cur <= next_player;
                default: ;
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score;

    // Only a good hit can raise a score, so only that path can raise the maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            high_score <= '0;
        end else if (state == S_PLAY && !bottom_e && !bad_e && good_e && score_add > high_score) begin
            high_score <= score_add;
        end
    end

    assign highScore = high_score;
`else
    assign highScore = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_player_game_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_player_game_controller
// Brief    : Scoreboard bench; a game-level model queues the expected state at
//            each launch, ball loss and game over, and a monitor checks them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_player_game_controller;
    localparam int NP   = 2;
    localparam int LI   = 3;
    localparam int LM   = 9;
    localparam int SW   = 8;
    localparam int RF   = 30;
    localparam int SMAX = (1 << SW) - 1;
    localparam int K_LAUNCH = 0;
    localparam int K_LOST   = 1;
    localparam int K_OVER   = 2;

    logic          clk = 1'b0;
    logic          reset, sof, start, key5, c_good, c_bad, c_bottom, c_credit;
    logic [3:0]    num_in;
    logic          pause, reset_level, reset_level_pulse, gameOver;
    logic [3:0]    life;
    logic [SW-1:0] score, highScore;
    logic [1:0]    currentPlayer, winner;

    always #5 clk = ~clk;

    multi_player_game_controller #(
        .NUM_PLAYERS(NP), .LIVES_INIT(LI), .LIVES_MAX(LM), .SCORE_W(SW), .RESET_FRAMES(RF)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .start(start), .key5IsPressed(key5),
        .collisionBallObstacleGood(c_good), .collisionBallObstacleBad(c_bad),
        .collisionBallBottom(c_bottom), .collisionBallCredit(c_credit), .scoreNumber(num_in),
        .pause(pause), .reset_level(reset_level), .reset_level_pulse(reset_level_pulse),
        .life(life), .score(score), .currentPlayer(currentPlayer), .gameOver(gameOver),
        .winner(winner), .highScore(highScore)
    );

    typedef struct { int kind; int a; int b; int c; } exp_t;
    exp_t exp_q[$];
    int   checks = 0, failures = 0, pushed = 0, consumed = 0;

    int   m_lives [4];
    int   m_scores[4];
    int   m_cur, m_hs;
    bit   m_over;

    task automatic chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- game model ----------------
    function automatic void m_load();
        for (int i = 0; i < 4; i++) begin
            m_lives[i]  = (i < NP) ? LI : 0;
            m_scores[i] = 0;
        end
        m_cur  = 0;
        m_over = 0;
    endfunction

    function automatic void m_event(bit g, bit b, bit c, int n);
        if (b)      m_scores[m_cur] = (m_scores[m_cur] > n) ? m_scores[m_cur] - n : 0;
        else if (g) begin
            m_scores[m_cur] = (m_scores[m_cur] + n > SMAX) ? SMAX : m_scores[m_cur] + n;
            if (m_scores[m_cur] > m_hs) m_hs = m_scores[m_cur];
        end
        else if (c) m_lives[m_cur] = (m_lives[m_cur] + 1 > LM) ? LM : m_lives[m_cur] + 1;
    endfunction

    function automatic bit m_next();
        for (int k = 1; k <= NP; k++) begin
            if (m_lives[(m_cur + k) % NP] > 0) begin
                m_cur = (m_cur + k) % NP;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int m_winner();
        int w = 0;
        for (int i = 1; i < NP; i++) if (m_scores[i] > m_scores[w]) w = i;
        return w;
    endfunction

    function automatic int exp_hs();
`ifdef HIGH_SCORE_EN
        return m_hs;
`else
        return 0;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic push_exp(int kind, int a, int b, int c);
        exp_t e;
        e.kind = kind; e.a = a; e.b = b; e.c = c;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic pop_check(int kind, int a, int b, int c);
        exp_t  e;
        string nm;
        nm = (kind == K_LAUNCH) ? "launch" : (kind == K_LOST) ? "ball_lost" : "game_over";
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s: actual=event expected=none", nm);
        end else begin
            e = exp_q.pop_front();
            consumed++;
            chk({nm, "_event_kind"}, kind, e.kind);
            if (kind == K_OVER) begin
                chk("game_over_winner", a, e.a);
                chk("game_over_highscore", b, e.b);
                chk("game_over_life", c, e.c);
            end else begin
                chk({nm, "_player"}, a, e.a);
                chk({nm, "_life"}, b, e.b);
                chk({nm, "_score"}, c, e.c);
            end
        end
    endtask

    task automatic wait_consumed(string nm);
        int n = 0;
        while (consumed < pushed && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (consumed < pushed) begin
            failures++;
            $display("FAIL %s_timeout: actual=%0d events expected=%0d events", nm, consumed, pushed);
            exp_q.delete();
            pushed = consumed;
        end
    endtask

    initial begin : monitor
        logic prev_pause, prev_go;
        prev_pause = 1'b1;
        prev_go    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pause = 1'b1;
                prev_go    = 1'b0;
            end else begin
                if (reset_level_pulse)
                    pop_check(K_LAUNCH, int'(currentPlayer), int'(life), int'(score));
                if (gameOver && !prev_go)
                    pop_check(K_OVER, int'(winner), int'(highScore), int'(life));
                if (pause && !prev_pause) begin
                    @(negedge clk);
                    pop_check(K_LOST, int'(currentPlayer), int'(life), int'(score));
                end
                prev_pause = pause;
                prev_go    = gameOver;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic reset_checks(string nm);
        chk({nm, "_pause"}, int'(pause), 1);
        chk({nm, "_reset_level"}, int'(reset_level), 1);
        chk({nm, "_pulse"}, int'(reset_level_pulse), 0);
        chk({nm, "_life"}, int'(life), 0);
        chk({nm, "_score"}, int'(score), 0);
        chk({nm, "_player"}, int'(currentPlayer), 0);
        chk({nm, "_gameover"}, int'(gameOver), 0);
        chk({nm, "_winner"}, int'(winner), 0);
        chk({nm, "_highscore"}, int'(highScore), 0);
    endtask

    task automatic probe(string nm);
        chk({nm, "_life"}, int'(life), m_lives[m_cur]);
        chk({nm, "_score"}, int'(score), m_scores[m_cur]);
        chk({nm, "_player"}, int'(currentPlayer), m_cur);
    endtask

    task automatic do_start();
        m_load();
        push_exp(K_LAUNCH, 0, LI, 0);
        start = 1'b1; tick(1); start = 1'b0; tick(1);
        wait_consumed("start");
    endtask

    task automatic do_launch();
        key5 = 1'b1; tick(1); key5 = 1'b0; tick(1);
    endtask

    task automatic do_event(bit g, bit b, bit c, int n, int hold);
        m_event(g, b, c, n);
        c_good = g; c_bad = b; c_credit = c; num_in = 4'(n);
        tick(hold);
        c_good = 1'b0; c_bad = 1'b0; c_credit = 1'b0;
        tick(1);
    endtask

    task automatic lose_ball(bit g, bit b, bit c, int n);
        m_lives[m_cur]--;
        push_exp(K_LOST, m_cur, m_lives[m_cur], m_scores[m_cur]);
        c_bottom = 1'b1; c_good = g; c_bad = b; c_credit = c; num_in = 4'(n);
        tick(1);
        c_bottom = 1'b0; c_good = 1'b0; c_bad = 1'b0; c_credit = 1'b0;
        tick(1);
        wait_consumed("lost_ball");
        for (int f = 1; f <= RF; f++) begin
            if (f == RF) begin
                chk("reset_level_held", int'(reset_level), 1);
                if (m_next()) push_exp(K_LAUNCH, m_cur, m_lives[m_cur], m_scores[m_cur]);
                else begin
                    m_over = 1'b1;
                    push_exp(K_OVER, m_winner(), exp_hs(), 0);
                end
            end
            sof = 1'b1; tick(1); sof = 1'b0;
            tick(int'($urandom_range(3, 5)));
        end
        wait_consumed("next_turn");
    endtask

    task automatic simple_turn(int credits, int good_n);
        do_launch();
        repeat (credits) do_event(1'b0, 1'b0, 1'b1, 0, 1);
        if (good_n > 0) do_event(1'b1, 1'b0, 1'b0, good_n, 1);
        lose_ball(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic random_turn(int max_n);
        int r;
        bit g, b, c;
        do_launch();
        repeat (int'($urandom_range(2, 6))) begin
            r = int'($urandom_range(0, 9));
            g = (r <= 3); b = (r == 4 || r == 5); c = (r == 6);
            if (r >= 7) begin
                g = 1'($urandom_range(0, 1));
                b = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
            end
            do_event(g, b, c, int'($urandom_range(0, max_n)), int'($urandom_range(1, 3)));
        end
        probe("random_turn");
        lose_ball(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, max_n)));
    endtask

    task automatic random_rest(int max_n);
        int guard = 0;
        while (!m_over && guard < 40) begin
            random_turn(max_n);
            guard++;
        end
        chk("game_over_flag", int'(gameOver), 1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : driver
        reset = 1'b1; sof = 1'b0; start = 1'b0; key5 = 1'b0;
        c_good = 1'b0; c_bad = 1'b0; c_bottom = 1'b0; c_credit = 1'b0; num_in = 4'd0;
        m_hs = 0;
        m_load();
        tick(3);
        reset_checks("reset");
        reset = 1'b0;
        tick(2);

        // Game A: edge detection, priority drop, turn rotation with skip.
        do_start();
        do_launch();
        chk("play_pause", int'(pause), 0);
        chk("play_reset_level", int'(reset_level), 0);
        do_event(1'b1, 1'b0, 1'b0, 5, 10);
        probe("good_held");
        do_event(1'b0, 1'b1, 1'b0, 7, 1);
        probe("bad_floor");
        lose_ball(1'b1, 1'b0, 1'b0, 9);
        simple_turn(0, 6);
        simple_turn(2, 0);
        simple_turn(0, 0);
        simple_turn(0, 0);
        simple_turn(0, 0);
        simple_turn(0, 3);
        simple_turn(0, 0);
        chk("game_a_over_flag", int'(gameOver), 1);

        // Game B: saturation of lives and score, then random play.
        do_start();
        do_launch();
        repeat (7) do_event(1'b0, 1'b0, 1'b1, 0, 1);
        probe("life_saturate");
        repeat (17) do_event(1'b1, 1'b0, 1'b0, 15, 1);
        do_event(1'b1, 1'b0, 1'b0, 4, 1);
        probe("score_saturate");
        do_event(1'b0, 1'b1, 1'b0, 3, 2);
        probe("score_after_sat");
        lose_ball(1'b0, 1'b0, 1'b0, 0);
        random_rest(15);

        // Game C: zero-valued obstacles, so all scores tie and player 0 wins.
        do_start();
        random_rest(0);

        // Game D: reset in the middle of a turn.
        do_start();
        do_launch();
        do_event(1'b1, 1'b0, 1'b0, 8, 1);
        probe("pre_reset");
        reset = 1'b1;
        tick(2);
        m_hs = 0;
        m_load();
        reset_checks("midturn_reset");
        reset = 1'b0;
        tick(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
